// File: rtl/gate_test_pkg.sv
// Shared types and constants for the gate truth-table sequencer.
package gate_test_pkg;

   localparam int unsigned NUM_VEC = 4;
   localparam int unsigned IDX_W   = 2;
   localparam int unsigned ERR_W   = 3;
   localparam int unsigned LOG_W   = 2 * NUM_VEC;
   localparam int unsigned CNT_W   = 8;

   typedef enum logic [2:0] {
      IDLE,
      APPLY,
      SETTLE,
      SAMPLE,
      DONE
   } state_t;

   // Expected {and2, or2} for a vector given as {x2, x1}.
   function automatic logic [1:0] exp_resp(input logic [1:0] vec);
      return {vec[1] & vec[0], vec[1] | vec[0]};
   endfunction

endpackage

// File: rtl/gate_settle_timer.sv
// Settle down-counter: load at APPLY, count through SETTLE, expire on the last settle cycle.
module gate_settle_timer
   import gate_test_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             count,
   input  logic [CNT_W-1:0] load_val,
   output logic             expire_c
);

   logic [CNT_W-1:0] cnt;

   // Remaining settle cycles, including the current one.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (count && (cnt != '0)) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign expire_c = count && (cnt <= CNT_W'(1));

endmodule

// File: rtl/gate_test_seq.sv
// Truth-table sequencer for a 2-input AND/OR gate under test.
// Optional response capture into result_log is enabled by defining GATE_TEST_LOG_EN.
module gate_test_seq
   import gate_test_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 4
)
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               abort,
   output logic               x1,
   output logic               x2,
   input  logic               and2,
   input  logic               or2,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [ERR_W-1:0]   err_cnt,
   output logic [NUM_VEC-1:0] fail_vec,
   output logic [LOG_W-1:0]   result_log
);

   state_t             state, state_nxt;
   logic [IDX_W-1:0]   idx, idx_nxt;
   logic               x1_nxt, x2_nxt, busy_nxt, done_nxt, pass_nxt;
   logic [ERR_W-1:0]   err_nxt;
   logic [NUM_VEC-1:0] fail_nxt;
   logic               settle_load_c, settle_count_c, settle_expire_c;

   gate_settle_timer u_settle (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (settle_load_c),
      .count    (settle_count_c),
      .load_val (CNT_W'(SETTLE_CYCLES)),
      .expire_c (settle_expire_c)
   );

   // Next-state and next-output logic; abort overrides every active state.
   always_comb begin
      state_nxt      = state;
      idx_nxt        = idx;
      x1_nxt         = x1;
      x2_nxt         = x2;
      done_nxt       = 1'b0;
      pass_nxt       = pass;
      err_nxt        = err_cnt;
      fail_nxt       = fail_vec;
      settle_load_c  = 1'b0;
      settle_count_c = 1'b0;

      if ((state != IDLE) && abort) begin
         state_nxt = IDLE;
         x1_nxt    = 1'b0;
         x2_nxt    = 1'b0;
         pass_nxt  = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start && !abort) begin
                  state_nxt        = APPLY;
                  idx_nxt          = '0;
                  err_nxt          = '0;
                  fail_nxt         = '0;
                  pass_nxt         = 1'b0;
                  {x2_nxt, x1_nxt} = 2'b00;
               end
            end
            APPLY: begin
               settle_load_c = 1'b1;
               state_nxt     = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
            end
            SETTLE: begin
               settle_count_c = 1'b1;
               if (settle_expire_c) begin
                  state_nxt = SAMPLE;
               end
            end
            SAMPLE: begin
               if ({and2, or2} != exp_resp({x2, x1})) begin
                  fail_nxt[idx] = 1'b1;
                  err_nxt       = err_cnt + ERR_W'(1);
               end
               if (idx == IDX_W'(NUM_VEC - 1)) begin
                  state_nxt = DONE;
                  done_nxt  = 1'b1;
                  pass_nxt  = (err_nxt == '0);
                  x1_nxt    = 1'b0;
                  x2_nxt    = 1'b0;
               end else begin
                  state_nxt        = APPLY;
                  idx_nxt          = idx + IDX_W'(1);
                  {x2_nxt, x1_nxt} = idx_nxt;
               end
            end
            DONE: begin
               state_nxt = IDLE;
            end
            default: begin
               state_nxt = IDLE;
            end
         endcase
      end

      busy_nxt = (state_nxt != IDLE);
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         idx      <= '0;
         x1       <= 1'b0;
         x2       <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         pass     <= 1'b0;
         err_cnt  <= '0;
         fail_vec <= '0;
      end else begin
         state    <= state_nxt;
         idx      <= idx_nxt;
         x1       <= x1_nxt;
         x2       <= x2_nxt;
         busy     <= busy_nxt;
         done     <= done_nxt;
         pass     <= pass_nxt;
         err_cnt  <= err_nxt;
         fail_vec <= fail_nxt;
      end
   end

`ifdef GATE_TEST_LOG_EN
   logic [LOG_W-1:0] log_q, log_nxt;

   // Response capture: cleared on an accepted start, written once per SAMPLE.
   always_comb begin
      log_nxt = log_q;
      if ((state == IDLE) && start && !abort) begin
         log_nxt = '0;
      end else if ((state == SAMPLE) && !abort) begin
         log_nxt[{idx, 1'b0} +: 2] = {and2, or2};
      end
   end

   // Log register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         log_q <= '0;
      end else begin
         log_q <= log_nxt;
      end
   end

   assign result_log = log_q;
`else
   assign result_log = '0;
`endif

endmodule
